// File: rtl/usb_frame_decoder.sv
// Receive-side frame decoder: hunts for sync headers, forwards payload (data cut-through,
// instructions as registered strobes) and validates the XOR trailer.
module usb_frame_decoder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [15:0] SYNC       = 16'hA5C3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  sys_clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  data_o_valid,
  input  logic                  data_o_ready,
  output logic [DATA_WIDTH-1:0] data_o_data,
  output logic                  data_o_last,
  output logic                  instr_o_en,
  output logic [DATA_WIDTH-1:0] instr_o_data,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam logic [3:0] TypeData  = 4'd1;
  localparam logic [3:0] TypeInstr = 4'd2;

  typedef enum logic [1:0] {StHunt, StPayload, StCheck} state_e;

  state_e                state;
  logic [3:0]            frame_type;
  logic [7:0]            remaining;
  logic [DATA_WIDTH-1:0] csum;
  logic                  xfer;
  logic                  type_valid;

  assign type_valid = (frame_type == TypeData) || (frame_type == TypeInstr);

  // Only data frames are throttled by the sink; everything else is always accepted.
  always_comb begin
    in_ready = 1'b0;
    if (resetn) begin
      unique case (state)
        StHunt:    in_ready = 1'b1;
        StPayload: in_ready = (frame_type == TypeData) ? data_o_ready : 1'b1;
        StCheck:   in_ready = 1'b1;
        default:   in_ready = 1'b0;
      endcase
    end
  end

  assign xfer         = in_valid && in_ready;
  assign data_o_valid = resetn && (state == StPayload) && (frame_type == TypeData) && in_valid;
  assign data_o_data  = data_o_valid ? in_data : '0;
  assign data_o_last  = data_o_valid && (remaining == 8'd1);

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state        <= StHunt;
      frame_type   <= 4'd0;
      remaining    <= 8'd0;
      csum         <= '0;
      instr_o_en   <= 1'b0;
      instr_o_data <= '0;
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;
      frame_cnt    <= '0;
      err_cnt      <= '0;
    end else begin
      instr_o_en <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      if (xfer) begin
        unique case (state)
          StHunt: begin
            // Non-sync words are dropped without reporting an error.
            if (in_data[31:16] == SYNC) begin
              if (in_data[7:0] == 8'd0) begin
                frame_err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_WIDTH'(1);
              end else begin
                frame_type <= in_data[15:12];
                remaining  <= in_data[7:0];
                csum       <= in_data;
                state      <= StPayload;
              end
            end
          end
          StPayload: begin
            csum      <= csum ^ in_data;
            remaining <= remaining - 8'd1;
            if (frame_type == TypeInstr) begin
              instr_o_en   <= 1'b1;
              instr_o_data <= in_data;
            end
            if (remaining == 8'd1) state <= StCheck;
          end
          StCheck: begin
            if ((in_data == csum) && type_valid) begin
              frame_ok <= 1'b1;
              if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            end else begin
              frame_err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_WIDTH'(1);
            end
            state <= StHunt;
          end
          default: state <= StHunt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_frame_decoder.sv
// Randomized bench for usb_frame_decoder; a frame-level model predicts the payload streams,
// strobes and saturating counters (narrow counters so saturation is reachable).
module tb_usb_frame_decoder;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [15:0] SYNC = 16'hA5C3;

  logic          sys_clk, resetn, in_valid, in_ready, data_o_valid, data_o_ready, data_o_last;
  logic [31:0]   in_data, data_o_data, instr_o_data;
  logic          instr_o_en, frame_ok, frame_err;
  logic [CW-1:0] frame_cnt, err_cnt;

  usb_frame_decoder #(.DATA_WIDTH(32), .SYNC(SYNC), .CNT_WIDTH(CW)) dut (
    .sys_clk(sys_clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .data_o_valid(data_o_valid), .data_o_ready(data_o_ready),
    .data_o_data(data_o_data), .data_o_last(data_o_last), .instr_o_en(instr_o_en),
    .instr_o_data(instr_o_data), .frame_ok(frame_ok), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_fcnt = 0;
  int exp_ecnt = 0;
  logic [32:0] got_data[$];
  int got_instr, got_ok, got_err;
  bit rand_ready = 0;
  int ready_pct = 50;
  bit bubbles = 0;

  initial sys_clk = 0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    #1;
    if (rand_ready) data_o_ready = ($urandom_range(99) < ready_pct);
  end

  always @(negedge sys_clk) begin
    if (resetn) begin
      if (data_o_valid && data_o_ready) got_data.push_back({data_o_last, data_o_data});
      if (instr_o_en) got_instr++;
      if (frame_ok) got_ok++;
      if (frame_err) got_err++;
    end
  end

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic send_word(input logic [31:0] w);
    bit acc;
    if (bubbles) repeat ($urandom_range(2)) begin
      in_valid = 1'b0;
      @(posedge sys_clk); #1;
    end
    in_data  = w;
    in_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge sys_clk);
      acc = in_ready;
      @(posedge sys_clk); #1;
      if (acc) break;
      if (t > 300) begin
        checks++; errors++;
        $display("FAIL send_timeout word=%h never accepted", w);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic clear_obs();
    got_data.delete();
    got_instr = 0; got_ok = 0; got_err = 0;
  endtask

  // Drives one frame starting with a sync header and checks it against the frame model.
  task automatic run_frame(input string name, input logic [31:0] hdr, input logic [31:0] pl[$],
                           input logic [31:0] trailer);
    logic [32:0] exp_data[$];
    logic [31:0] x;
    logic [3:0]  typ;
    int len, exp_instr, exp_ok, exp_err;
    typ = hdr[15:12];
    len = int'(hdr[7:0]);
    x = hdr;
    exp_instr = 0; exp_ok = 0; exp_err = 0;
    clear_obs();
    if (len == 0) begin
      exp_err = 1;
    end else begin
      for (int i = 0; i < len; i++) begin
        x = x ^ pl[i];
        if (typ == 4'd1) exp_data.push_back({i == len - 1, pl[i]});
      end
      if (typ == 4'd2) exp_instr = len;
      if (trailer == x && (typ == 4'd1 || typ == 4'd2)) exp_ok = 1; else exp_err = 1;
    end
    if (exp_ok == 1) exp_fcnt = sat(exp_fcnt); else exp_ecnt = sat(exp_ecnt);

    send_word(hdr);
    for (int i = 0; i < len; i++) begin
      send_word(pl[i]);
      if (typ == 4'd2) begin
        checks++;
        if (instr_o_en !== 1'b1 || instr_o_data !== pl[i]) begin
          errors++;
          $display("FAIL %s instr_strobe got en=%b data=%h exp en=1 data=%h",
                   name, instr_o_en, instr_o_data, pl[i]);
        end
      end
    end
    if (len != 0) send_word(trailer);
    checks++;
    if (frame_ok !== exp_ok[0] || frame_err !== exp_err[0]) begin
      errors++;
      $display("FAIL %s strobe_timing got ok=%b err=%b exp ok=%0d err=%0d",
               name, frame_ok, frame_err, exp_ok, exp_err);
    end
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL %s data_count got %0d exp %0d", name, got_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        checks++;
        if (got_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL %s data_word[%0d] got %h exp %h", name, i, got_data[i], exp_data[i]);
        end
      end
    end
    checks++;
    if (got_instr != exp_instr || got_ok != exp_ok || got_err != exp_err) begin
      errors++;
      $display("FAIL %s pulse_counts got instr=%0d ok=%0d err=%0d exp instr=%0d ok=%0d err=%0d",
               name, got_instr, got_ok, got_err, exp_instr, exp_ok, exp_err);
    end
    checks++;
    if (frame_cnt !== exp_fcnt[CW-1:0] || err_cnt !== exp_ecnt[CW-1:0]) begin
      errors++;
      $display("FAIL %s counters got frame=%0d err=%0d exp frame=%0d err=%0d",
               name, frame_cnt, err_cnt, exp_fcnt, exp_ecnt);
    end
  endtask

  function automatic logic [31:0] xor_all(input logic [31:0] hdr, input logic [31:0] pl[$]);
    logic [31:0] x = hdr;
    foreach (pl[i]) x = x ^ pl[i];
    return x;
  endfunction

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({in_ready, data_o_valid, data_o_data, data_o_last, instr_o_en, instr_o_data,
         frame_ok, frame_err, frame_cnt, err_cnt} !== '0) begin
      errors++;
      $display("FAIL %s outputs_zero got rdy=%b dv=%b dd=%h dl=%b ie=%b id=%h ok=%b err=%b fc=%0d ec=%0d exp all 0",
               name, in_ready, data_o_valid, data_o_data, data_o_last, instr_o_en,
               instr_o_data, frame_ok, frame_err, frame_cnt, err_cnt);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; data_o_ready = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check_idle_outputs("reset");
    @(negedge sys_clk);
    resetn = 1'b1;
    exp_fcnt = 0; exp_ecnt = 0;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_data_frame();
    logic [31:0] pl[$] = '{32'h11, 32'h22, 32'h33};
    run_frame("data_frame", 32'hA5C3_1003, pl, xor_all(32'hA5C3_1003, pl));
  endtask

  task automatic test_instr_frame();
    logic [31:0] pl[$] = '{32'h0000_0105};
    run_frame("instr_frame", 32'hA5C3_2001, pl, xor_all(32'hA5C3_2001, pl));
  endtask

  task automatic test_backpressure();
    logic [31:0] pl[$] = '{32'h11, 32'h22, 32'h33};
    rand_ready = 1; ready_pct = 35;
    for (int k = 0; k < 3; k++)
      run_frame("backpressure", 32'hA5C3_1003, pl, xor_all(32'hA5C3_1003, pl));
    rand_ready = 0; data_o_ready = 1'b1;
  endtask

  task automatic test_bad_trailer();
    logic [31:0] pl[$] = '{32'h11, 32'h22, 32'h33};
    run_frame("bad_trailer", 32'hA5C3_1003, pl, xor_all(32'hA5C3_1003, pl) ^ 32'h1);
  endtask

  task automatic test_junk_len0();
    logic [31:0] pl[$] = '{32'hDEAD_BEEF, 32'h0BAD_F00D};
    logic [31:0] none[$];
    clear_obs();
    send_word(32'h1234_5678);
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if (got_err != 0 || err_cnt !== exp_ecnt[CW-1:0]) begin
      errors++;
      $display("FAIL junk_silent got err_pulses=%0d err_cnt=%0d exp 0 and %0d",
               got_err, err_cnt, exp_ecnt);
    end
    run_frame("len0", 32'hA5C3_1000, none, 32'h0);
    run_frame("after_len0", 32'hA5C3_1002, pl, xor_all(32'hA5C3_1002, pl));
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] pl[$] = '{32'h11, 32'h22, 32'h33};
    send_word(32'hA5C3_1003);
    send_word(32'h11);
    send_word(32'h22);
    #2 resetn = 1'b0;
    #1 check_idle_outputs("reset_mid_frame");
    @(negedge sys_clk);
    resetn = 1'b1;
    exp_fcnt = 0; exp_ecnt = 0;
    clear_obs();
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (got_ok != 0 || got_err != 0 || got_data.size() != 0) begin
      errors++;
      $display("FAIL reset_no_strobe got ok=%0d err=%0d data=%0d exp 0 0 0",
               got_ok, got_err, got_data.size());
    end
    run_frame("fresh_after_reset", 32'hA5C3_1003, pl, xor_all(32'hA5C3_1003, pl));
  endtask

  task automatic test_random();
    logic [3:0] types[5] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd7};
    rand_ready = 1; ready_pct = 60; bubbles = 1;
    for (int f = 0; f < 40; f++) begin
      logic [31:0] pl[$];
      logic [31:0] hdr, tr, junk;
      int len;
      if ($urandom_range(3) == 0) begin
        junk = $urandom;
        junk[31:16] = SYNC ^ 16'(1 + $urandom_range(1000));
        send_word(junk);
      end
      len = ($urandom_range(9) == 0) ? 0 : 1 + $urandom_range(5);
      hdr = {SYNC, types[$urandom_range(4)], 4'h0, 8'(len)};
      pl.delete();
      // Some payload words mimic headers; they must not cause a resync.
      for (int i = 0; i < len; i++)
        pl.push_back(($urandom_range(4) == 0) ? {SYNC, 16'($urandom)} : 32'($urandom));
      tr = xor_all(hdr, pl);
      if ($urandom_range(5) == 0) tr = tr ^ (32'h1 << $urandom_range(31));
      run_frame("random", hdr, pl, tr);
    end
    rand_ready = 0; data_o_ready = 1'b1; bubbles = 0;
  endtask

  task automatic test_saturation();
    logic [31:0] none[$];
    logic [31:0] pl[$] = '{32'h5A5A_0001};
    for (int i = 0; i < CMAX + 2; i++) run_frame("sat_err", 32'hA5C3_2000, none, 32'h0);
    for (int i = 0; i < CMAX + 2; i++)
      run_frame("sat_ok", 32'hA5C3_1001, pl, xor_all(32'hA5C3_1001, pl));
  endtask

  initial begin
    test_reset();
    test_data_frame();
    test_instr_frame();
    test_backpressure();
    test_bad_trailer();
    test_junk_len0();
    test_reset_mid_frame();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
